pcapwriter_10gbmac: RTL and testbench
=====================================

Name: pcapwriter_10gbmac

Overview:
- Avalon-ST 64-bit packet sink; the capture-side counterpart of the pcap parser source on the same bus.
- Stores one packet at a time, stamps it with a simulated-time timestamp, and serialises it as a libpcap byte stream on an 8-bit valid/ready output.
- The output feeds a file dumper or UART bridge, so bench and FPGA traffic can be opened in Wireshark.

Parameters:
- max_words, 256: packet buffer depth in 64-bit words; snaplen = max_words*8 bytes.
- clk_period_ns, 4: nanoseconds added to the timestamp per clock.
- linktype, 1: pcap network field (1 = Ethernet).

Ports:
- clk_in  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- asi_in_data  in  64  beat data; byte 0 on [7:0], byte 7 on [63:56].
- asi_in_valid  in  1  beat valid.
- asi_in_ready  out  1  sink ready; a beat transfers when valid && ready.
- asi_in_sop  in  1  start of packet.
- asi_in_eop  in  1  end of packet.
- asi_in_empty  in  3  unused bytes in the eop beat (high bytes); ignored when eop=0.
- asi_in_error  in  6  nonzero on any beat marks the packet bad.
- pcap_data  out  8  output byte.
- pcap_valid  out  1  output byte valid.
- pcap_ready  in  1  downstream accept.
- pktcount  out  8  packets written; wraps at 255.
- dropcount  out  8  packets/beats discarded; wraps at 255.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert on clk_in):
  - state=GHDR, asi_in_ready=0, pcap_valid=0, pcap_data=0.
  - pktcount=0, dropcount=0, timestamp={sec=0, nsec=0}.
  - Any buffered packet is lost; the global header is re-emitted after every reset.
- Timestamp:
  - nsec += clk_period_ns every cycle.
  - When nsec+clk_period_ns >= 1_000_000_000: nsec wraps to (nsec+clk_period_ns-1e9) and sec += 1.
  - sec is 32-bit and wraps to 0.
- Output handshake:
  - A byte transfers on pcap_valid && pcap_ready.
  - pcap_data and pcap_valid hold stable while valid && !ready.
  - One byte per cycle maximum.
- GHDR state: emits 24 bytes, then goes to IDLE. asi_in_ready=0. Byte sequence:
  - 4D 3C B2 A1 (nanosecond magic, little-endian).
  - 02 00 04 00 (version 2.4).
  - 00 00 00 00 (thiszone), 00 00 00 00 (sigfigs).
  - snaplen as 4 bytes LE.
  - linktype as 4 bytes LE.
- IDLE state: asi_in_ready=1.
  - Beat with sop: latch timestamp in the same cycle; write word 0; go to CAPTURE. If eop is also set, it is a single-beat packet: finish it directly.
  - Beat without sop: discard; dropcount += 1.
- CAPTURE state: asi_in_ready=1.
  - Write each beat to the next word while wr_ptr < max_words; beats past that are discarded (truncation).
  - orig_len accumulates 8 per beat, or 8-empty on the eop beat.
  - incl_len = min(orig_len, max_words*8).
  - error != 0 on any beat sets a bad flag.
  - sop received mid-packet: abort the current packet (dropcount += 1); the sop beat starts a new packet with a new timestamp.
  - eop beat with bad flag: dropcount += 1, go to IDLE.
  - eop beat, packet good: go to RHDR. asi_in_ready is 0 from the next cycle.
- RHDR state: emits 16 bytes, each field 4 bytes LE: ts_sec, ts_nsec, incl_len, orig_len. Then go to PAYLOAD.
- PAYLOAD state:
  - Emits incl_len bytes: byte k comes from word k/8, lane k%8.
  - Buffer read latency is hidden; there are no bubbles when pcap_ready is held high.
  - After the last byte: pktcount += 1, go to IDLE.
- Output is never padded.
- Counter arithmetic:
  - 32-bit for lengths.
  - orig_len saturates at 2^32-1.
- Throughput is store-and-forward:
  - Input is stalled for 16+incl_len output transfers per packet.
  - There is no lost data under input backpressure.

Test Plan:
- Reset, pcap_ready=1, no input -> exactly 24 bytes appear: 4D 3C B2 A1 02 00 04 00 00 00 00 00 00 00 00 00 00 08 00 00 01 00 00 00. busy falls to 0 after them.
- 60-byte packet (8 beats, last empty=4; bytes 0x00..0x3B) sent at sop cycle N -> record header shows ts_nsec=N*4 LE, incl_len=orig_len=3C 00 00 00. Payload 00..3B follows. pktcount=1.
- Packet of 257 words with max_words=256 -> incl_len=2048, orig_len=2056. Exactly 2048 payload bytes are emitted.
- Packet with error=1 on beat 3 -> no bytes emitted, dropcount=1, pktcount unchanged. The next good packet is emitted normally.
- Stray beat without sop in IDLE, then sop mid-packet -> dropcount increments once for each. Only the second packet is emitted, with its own timestamp.
- pcap_ready toggled at random 50% during a 64-byte packet, plus a reset asserted mid-PAYLOAD -> bytes are never duplicated or skipped before the reset. After the reset the stream restarts with the 24-byte global header, and pktcount=0.

Source files
------------

// File: rtl/pcapwriter_10gbmac.sv
// Avalon-ST 64-bit packet sink that stores one packet at a time and replays it as a
// libpcap (nanosecond) byte stream on an 8-bit valid/ready output.
module pcapwriter_10gbmac #(
    parameter int max_words     = 256,
    parameter int clk_period_ns = 4,
    parameter int linktype      = 1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [63:0] asi_in_data,
    input  logic        asi_in_valid,
    output logic        asi_in_ready,
    input  logic        asi_in_sop,
    input  logic        asi_in_eop,
    input  logic [2:0]  asi_in_empty,
    input  logic [5:0]  asi_in_error,
    output logic [7:0]  pcap_data,
    output logic        pcap_valid,
    input  logic        pcap_ready,
    output logic [7:0]  pktcount,
    output logic [7:0]  dropcount,
    output logic        busy
);

    localparam int          AW       = (max_words > 1) ? $clog2(max_words) : 1;
    localparam int          PW       = AW + 1;
    localparam logic [31:0] SNAPLEN  = 32'(max_words * 8);
    localparam logic [31:0] PERIOD   = 32'(clk_period_ns);
    localparam logic [31:0] NS_PER_S = 32'd1000000000;
    localparam logic [191:0] GHDR    = {32'(linktype), SNAPLEN, 32'h0000_0000, 32'h0000_0000,
                                        16'h0004, 16'h0002, 32'hA1B2_3C4D};

    typedef enum logic [2:0] {
        S_GHDR    = 3'd0,
        S_IDLE    = 3'd1,
        S_CAPTURE = 3'd2,
        S_RHDR    = 3'd3,
        S_PAYLOAD = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [31:0]  r_cnt;
    logic [7:0]   r_pd;
    logic         r_pv;
    logic [7:0]   r_pkt;
    logic [7:0]   r_drop;
    logic [31:0]  r_sec;
    logic [31:0]  r_nsec;
    logic [31:0]  r_ts_sec;
    logic [31:0]  r_ts_nsec;
    logic [31:0]  r_orig;
    logic [31:0]  r_incl;
    logic         r_bad;
    logic [PW-1:0] r_wr_ptr;
    logic [63:0]  r_mem [max_words];

    logic         w_out_free;
    logic         w_load;
    logic [7:0]   w_byte;
    logic         w_last_byte;
    logic         w_take;
    logic         w_pkt_inc;
    logic [1:0]   w_drop_inc;
    logic         w_beat;
    logic [3:0]   w_add;
    logic [PW-1:0] w_ptr_cur;
    logic [31:0]  w_orig_cur;
    logic [32:0]  w_sum;
    logic [31:0]  w_orig_nxt;
    logic         w_bad_nxt;
    logic         w_wr_ok;
    logic [127:0] w_rhdr;
    logic [63:0]  w_rd_word;
    logic [31:0]  w_nsec_sum;

    assign asi_in_ready = (r_state == S_IDLE) || (r_state == S_CAPTURE);
    assign busy         = (r_state != S_IDLE);
    assign pcap_data    = r_pd;
    assign pcap_valid   = r_pv;
    assign pktcount     = r_pkt;
    assign dropcount    = r_drop;

    // A sop beat restarts length, pointer and bad-flag accumulation from zero.
    assign w_beat     = asi_in_valid && asi_in_ready;
    assign w_add      = asi_in_eop ? (4'd8 - {1'b0, asi_in_empty}) : 4'd8;
    assign w_ptr_cur  = asi_in_sop ? {PW{1'b0}} : r_wr_ptr;
    assign w_orig_cur = asi_in_sop ? 32'd0 : r_orig;
    assign w_sum      = {1'b0, w_orig_cur} + {29'd0, w_add};
    assign w_orig_nxt = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    assign w_bad_nxt  = (asi_in_sop ? 1'b0 : r_bad) | (|asi_in_error);
    assign w_wr_ok    = (w_ptr_cur < PW'(max_words));
    assign w_out_free = !r_pv || pcap_ready;
    assign w_rhdr     = {r_orig, r_incl, r_ts_nsec, r_ts_sec};
    assign w_rd_word  = r_mem[r_cnt[AW+2:3]];
    assign w_nsec_sum = r_nsec + PERIOD;

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_byte      = 8'h00;
        w_last_byte = 1'b0;
        w_take      = 1'b0;
        w_pkt_inc   = 1'b0;
        w_drop_inc  = 2'd0;
        case (r_state)
            S_GHDR: begin
                w_load      = w_out_free;
                w_byte      = GHDR[{r_cnt[4:0], 3'b000} +: 8];
                w_last_byte = (r_cnt == 32'd23);
                if (w_load && w_last_byte) w_state_nxt = S_IDLE;
                else                       w_state_nxt = S_GHDR;
            end
            S_IDLE, S_CAPTURE: begin
                if (!w_beat) begin
                    w_state_nxt = r_state;
                end else if ((r_state == S_IDLE) && !asi_in_sop) begin
                    w_drop_inc = 2'd1;
                end else begin
                    w_take     = 1'b1;
                    w_drop_inc = ((r_state == S_CAPTURE) && asi_in_sop) ? 2'd1 : 2'd0;
                    if (!asi_in_eop) begin
                        w_state_nxt = S_CAPTURE;
                    end else if (w_bad_nxt) begin
                        w_drop_inc  = w_drop_inc + 2'd1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_RHDR;
                    end
                end
            end
            S_RHDR: begin
                w_load      = w_out_free;
                w_byte      = w_rhdr[{r_cnt[3:0], 3'b000} +: 8];
                w_last_byte = (r_cnt == 32'd15);
                if (w_load && w_last_byte) w_state_nxt = S_PAYLOAD;
                else                       w_state_nxt = S_RHDR;
            end
            S_PAYLOAD: begin
                w_load      = w_out_free;
                w_byte      = w_rd_word[{r_cnt[2:0], 3'b000} +: 8];
                w_last_byte = (r_cnt == (r_incl - 32'd1));
                if (w_load && w_last_byte) begin
                    w_pkt_inc   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_PAYLOAD;
                end
            end
            default: w_state_nxt = S_GHDR;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) r_state <= S_GHDR;
        else       r_state <= w_state_nxt;
    end

    // Output byte register; the byte counter advances only when a new byte is loaded.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_pd  <= 8'h00;
            r_pv  <= 1'b0;
            r_cnt <= 32'd0;
        end else if (w_load) begin
            r_pd  <= w_byte;
            r_pv  <= 1'b1;
            r_cnt <= w_last_byte ? 32'd0 : (r_cnt + 32'd1);
        end else if (pcap_ready) begin
            r_pv  <= 1'b0;
        end
    end

    // Capture bookkeeping: pointer, lengths, bad flag and the packet timestamp.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= {PW{1'b0}};
            r_orig    <= 32'd0;
            r_incl    <= 32'd0;
            r_bad     <= 1'b0;
            r_ts_sec  <= 32'd0;
            r_ts_nsec <= 32'd0;
        end else if (w_take) begin
            r_wr_ptr <= w_wr_ok ? (w_ptr_cur + {{(PW-1){1'b0}}, 1'b1}) : w_ptr_cur;
            r_orig   <= w_orig_nxt;
            r_bad    <= w_bad_nxt;
            if (asi_in_sop) begin
                r_ts_sec  <= r_sec;
                r_ts_nsec <= r_nsec;
            end
            if (asi_in_eop) begin
                r_incl <= (w_orig_nxt > SNAPLEN) ? SNAPLEN : w_orig_nxt;
            end
        end
    end

    // Packet buffer; beats beyond the buffer depth are truncated.
    always_ff @(posedge clk_in) begin
        if (w_take && w_wr_ok) begin
            r_mem[w_ptr_cur[AW-1:0]] <= asi_in_data;
        end
    end

    // Free-running simulated-time clock.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sec  <= 32'd0;
            r_nsec <= 32'd0;
        end else if (w_nsec_sum >= NS_PER_S) begin
            r_nsec <= w_nsec_sum - NS_PER_S;
            r_sec  <= r_sec + 32'd1;
        end else begin
            r_nsec <= w_nsec_sum;
        end
    end

    // Written/dropped packet counters, both wrapping.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_pkt  <= 8'd0;
            r_drop <= 8'd0;
        end else begin
            r_pkt  <= r_pkt + {7'd0, w_pkt_inc};
            r_drop <= r_drop + {6'd0, w_drop_inc};
        end
    end

endmodule

// File: tb/tb_pcapwriter_10gbmac.sv
// Directed bench for pcapwriter_10gbmac: global header, record framing, truncation,
// error/stray/abort drops, output backpressure and reset restart.
module tb_pcapwriter_10gbmac;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic [63:0] asi_in_data = 64'd0;
    logic        asi_in_valid = 1'b0;
    logic        asi_in_ready;
    logic        asi_in_sop = 1'b0;
    logic        asi_in_eop = 1'b0;
    logic [2:0]  asi_in_empty = 3'd0;
    logic [5:0]  asi_in_error = 6'd0;
    logic [7:0]  pcap_data;
    logic        pcap_valid;
    logic        pcap_ready = 1'b1;
    logic [7:0]  pktcount;
    logic [7:0]  dropcount;
    logic        busy;

    int nvec = 0;
    int nerr = 0;
    int cyc;
    int hold_bad = 0;
    logic       hold = 1'b0;
    logic [7:0] held_d = 8'h00;
    logic [7:0] cap_q [$];

    logic [7:0] ghdr_exp [24] = '{8'h4D, 8'h3C, 8'hB2, 8'hA1, 8'h02, 8'h00, 8'h04, 8'h00,
                                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                  8'h00, 8'h08, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};

    pcapwriter_10gbmac dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .asi_in_data  (asi_in_data),
        .asi_in_valid (asi_in_valid),
        .asi_in_ready (asi_in_ready),
        .asi_in_sop   (asi_in_sop),
        .asi_in_eop   (asi_in_eop),
        .asi_in_empty (asi_in_empty),
        .asi_in_error (asi_in_error),
        .pcap_data    (pcap_data),
        .pcap_valid   (pcap_valid),
        .pcap_ready   (pcap_ready),
        .pktcount     (pktcount),
        .dropcount    (dropcount),
        .busy         (busy)
    );

    always #5 clk_in = ~clk_in;

    // Clock edges since the last reset release.
    always @(posedge clk_in or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Byte collector plus hold-stability watch on the output.
    always @(posedge clk_in) begin
        if (reset) begin
            hold <= 1'b0;
        end else begin
            if (hold && !(pcap_valid === 1'b1 && pcap_data === held_d)) hold_bad <= hold_bad + 1;
            if (pcap_valid === 1'b1 && pcap_ready === 1'b1) cap_q.push_back(pcap_data);
            hold   <= pcap_valid && !pcap_ready;
            held_d <= pcap_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q32(input int i);
        if (i + 3 < cap_q.size()) return {cap_q[i+3], cap_q[i+2], cap_q[i+1], cap_q[i]};
        else                      return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [7:0] rec_byte(input int i, input int seed, input int incl,
                                            input int orig, input int stamp);
        logic [127:0] h;
        h = {32'(orig), 32'(incl), 32'(stamp * 4), 32'd0};
        if (i < 16) return h[i*8 +: 8];
        else        return 8'(i - 16 + seed);
    endfunction

    task automatic send_beats(input int nbeats, input int last_empty, input int seed,
                              input int err_beat, input bit with_sop, input bit with_eop,
                              output int stamp);
        int  t;
        bit  ok;
        ok    = 1'b1;
        stamp = 0;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk_in);
            asi_in_valid = 1'b1;
            for (int j = 0; j < 8; j++) asi_in_data[j*8 +: 8] = 8'(b * 8 + j + seed);
            asi_in_sop   = with_sop && (b == 0);
            asi_in_eop   = with_eop && (b == nbeats - 1);
            asi_in_empty = asi_in_eop ? 3'(last_empty) : 3'd0;
            asi_in_error = (b == err_beat) ? 6'd1 : 6'd0;
            t = 0;
            while (asi_in_ready !== 1'b1 && t < 100) begin
                @(negedge clk_in);
                t++;
            end
            if (t >= 100) ok = 1'b0;
            if (b == 0) stamp = cyc;
            @(posedge clk_in);
        end
        @(negedge clk_in);
        asi_in_valid = 1'b0;
        asi_in_sop   = 1'b0;
        asi_in_eop   = 1'b0;
        asi_in_error = 6'd0;
        chk("beats_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk_in);
            if (busy === 1'b0 && pcap_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_reached", 64'(ok), 64'd1);
        repeat (2) @(negedge clk_in);
    endtask

    task automatic check_ghdr(input int base);
        int nbad;
        nbad = 0;
        chk("ghdr_len", 64'(cap_q.size() - base), 64'd24);
        for (int i = 0; i < 24; i++)
            if (base + i >= cap_q.size() || cap_q[base+i] !== ghdr_exp[i]) nbad++;
        chk("ghdr_bytes", 64'(nbad), 64'd0);
    endtask

    task automatic check_rec(input int base, input int seed, input int incl,
                             input int orig, input int stamp);
        int nbad;
        nbad = 0;
        chk("rec_len",  64'(cap_q.size() - base), 64'(16 + incl));
        chk("ts_sec",   64'(q32(base)),      64'd0);
        chk("ts_nsec",  64'(q32(base + 4)),  64'(32'(stamp * 4)));
        chk("incl_len", 64'(q32(base + 8)),  64'(incl));
        chk("orig_len", 64'(q32(base + 12)), 64'(orig));
        for (int k = 0; k < incl; k++)
            if (base + 16 + k >= cap_q.size() || cap_q[base+16+k] !== 8'(k + seed)) nbad++;
        chk("payload", 64'(nbad), 64'd0);
    endtask

    initial begin
        int base;
        int st;
        int st_b;
        int n;
        int nbad;

        // Reset state.
        repeat (3) @(negedge clk_in);
        chk("rst_pcap_valid", 64'(pcap_valid),   64'd0);
        chk("rst_pcap_data",  64'(pcap_data),    64'd0);
        chk("rst_in_ready",   64'(asi_in_ready), 64'd0);
        chk("rst_pktcount",   64'(pktcount),     64'd0);
        chk("rst_dropcount",  64'(dropcount),    64'd0);
        chk("rst_busy",       64'(busy),         64'd1);
        reset = 1'b0;

        // Global header.
        base = cap_q.size();
        wait_idle(100);
        check_ghdr(base);
        chk("idle_busy",     64'(busy),         64'd0);
        chk("idle_in_ready", 64'(asi_in_ready), 64'd1);

        // 60-byte packet.
        base = cap_q.size();
        send_beats(8, 4, 0, -1, 1'b1, 1'b1, st);
        wait_idle(300);
        check_rec(base, 0, 60, 60, st);
        chk("pkt1_count", 64'(pktcount), 64'd1);

        // 257-word packet truncated to the 256-word buffer.
        base = cap_q.size();
        send_beats(257, 0, 16, -1, 1'b1, 1'b1, st);
        wait_idle(3000);
        check_rec(base, 16, 2048, 2056, st);
        chk("trunc_count", 64'(pktcount), 64'd2);
        chk("trunc_drops", 64'(dropcount), 64'd0);

        // Error on beat 3 drops the packet; the next one goes through.
        base = cap_q.size();
        send_beats(5, 0, 7, 3, 1'b1, 1'b1, st);
        wait_idle(100);
        chk("err_no_bytes",  64'(cap_q.size() - base), 64'd0);
        chk("err_dropcount", 64'(dropcount), 64'd1);
        chk("err_pktcount",  64'(pktcount),  64'd2);
        base = cap_q.size();
        send_beats(2, 1, 85, -1, 1'b1, 1'b1, st);
        wait_idle(200);
        check_rec(base, 85, 15, 15, st);
        chk("after_err_count", 64'(pktcount), 64'd3);

        // Stray beat, then a packet aborted by a new sop.
        base = cap_q.size();
        send_beats(1, 0, 0, -1, 1'b0, 1'b0, st);
        chk("stray_drop", 64'(dropcount), 64'd2);
        send_beats(3, 0, 32, -1, 1'b1, 1'b0, st);
        send_beats(3, 2, 128, -1, 1'b1, 1'b1, st_b);
        wait_idle(200);
        chk("abort_drop", 64'(dropcount), 64'd3);
        check_rec(base, 128, 22, 22, st_b);
        chk("abort_pktcount", 64'(pktcount), 64'd4);

        // 64-byte packet under random backpressure, reset mid-payload.
        base = cap_q.size();
        send_beats(8, 0, 51, -1, 1'b1, 1'b1, st);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk_in);
            pcap_ready = 1'($urandom_range(0, 1));
            if (cap_q.size() >= base + 36) break;
        end
        reset = 1'b1;
        n = cap_q.size() - base;
        chk("mid_payload", 64'(n >= 36 && n < 80), 64'd1);
        nbad = 0;
        for (int i = 0; i < n; i++)
            if (cap_q[base+i] !== rec_byte(i, 51, 64, 64, st)) nbad++;
        chk("bp_prefix", 64'(nbad), 64'd0);
        #1;
        chk("rst2_pcap_valid", 64'(pcap_valid), 64'd0);
        chk("rst2_pktcount",   64'(pktcount),   64'd0);
        chk("rst2_busy",       64'(busy),       64'd1);
        repeat (2) @(negedge clk_in);
        pcap_ready = 1'b1;
        reset      = 1'b0;
        base = cap_q.size();
        wait_idle(100);
        check_ghdr(base);
        chk("rst2_pktcount_after", 64'(pktcount), 64'd0);
        chk("hold_stable", 64'(hold_bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
